// File: rtl/wb_csr_pkg.sv
// Shared types and constants for the Wishbone CSR bank: FSM encoding, CSR word map,
// and the byte-select expansion helper.
package wb_csr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMemReq,
    StMemCap,
    StAck
  } state_e;

  localparam logic [9:0] RO_BASE_W = 10'h010;
  localparam logic [9:0] STATUS_W  = 10'h020;
  localparam logic [9:0] IRQ_EN_W  = 10'h021;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_csr_bank_if.sv
// Wishbone B4 classic request/response bundle between the bus master and the CSR bank.
interface wb_csr_bank_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_csr_status.sv
// Sticky event STATUS register with W1C clear, IRQ enable register and registered irq.
module wb_csr_status
  import wb_csr_pkg::*;
#(
  parameter int unsigned NUM_STAT = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NUM_STAT-1:0] i_evt,
  input  logic [NUM_STAT-1:0] i_clr,
  input  logic                i_en_we,
  input  logic [NUM_STAT-1:0] i_en_wdata,
  input  logic [NUM_STAT-1:0] i_en_mask,
  output logic [NUM_STAT-1:0] o_status,
  output logic [NUM_STAT-1:0] o_irq_en,
  output logic                o_irq
);

  logic [NUM_STAT-1:0] r_status;
  logic [NUM_STAT-1:0] r_irq_en;
  logic                r_irq;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_status <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      // OR-ing the event after the clear lets a same-cycle event win.
      r_status <= (r_status & ~i_clr) | i_evt;
      if (i_en_we) begin
        r_irq_en <= (r_irq_en & ~i_en_mask) | (i_en_wdata & i_en_mask);
      end
      r_irq <= |(r_status & r_irq_en);
    end
  end

  assign o_status = r_status;
  assign o_irq_en = r_irq_en;
  assign o_irq    = r_irq;

endmodule

// File: rtl/wb_csr_bank.sv
// Wishbone CSR bank: R/W control words, RO status words, sticky events with irq,
// and a wait-stated read window into a synchronous RX packet memory.
module wb_csr_bank
  import wb_csr_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned          NUM_RW      = 8,
  parameter logic [NUM_RW*32-1:0] RW_INIT     = '0,
  parameter int unsigned          NUM_RO      = 4,
  parameter int unsigned          NUM_STAT    = 8,
  parameter logic [31:0]          RX_MEM_BASE = 32'h4000_0000,
  parameter int unsigned          RX_MEM_AW   = 12,
  parameter int unsigned          RX_MEM_DW   = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_csr_bank_if.slave         wbs,
  output logic [NUM_RW*32-1:0] rw_o,
  input  logic [NUM_RO*32-1:0] ro_i,
  input  logic [NUM_STAT-1:0]  stat_evt_i,
  output logic                 irq_o,
  output logic                 rx_mem_re_o,
  output logic [RX_MEM_AW-1:0] rx_mem_addr_o,
  input  logic [RX_MEM_DW-1:0] rx_mem_rdata_i
);

  state_e               r_state, w_state_nxt;
  logic [31:0]          r_rw [NUM_RW];
  logic [31:0]          r_dat;
  logic [RX_MEM_AW-1:0] r_rx_addr;

  logic [9:0]           w_idx;
  logic [31:0]          w_mask;
  logic [31:0]          w_csr_rdata;
  logic                 w_req, w_csr_hit, w_rx_hit, w_csr_wr, w_csr_rd, w_rx_rd;
  logic [NUM_STAT-1:0]  w_status, w_irq_en, w_clr;
  logic                 w_en_we;

  assign w_idx     = wbs.wbs_adr_i[11:2];
  assign w_mask    = sel_to_mask(wbs.wbs_sel_i);
  assign w_csr_hit = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign w_rx_hit  = !w_csr_hit &&
                     (wbs.wbs_adr_i[31:RX_MEM_AW] == RX_MEM_BASE[31:RX_MEM_AW]);
  assign w_req     = (r_state == StIdle) && wbs.wbs_stb_i && wbs.wbs_cyc_i;
  // Out-of-window accesses follow the CSR path and behave as unmapped words.
  assign w_csr_wr  = w_req && w_csr_hit && wbs.wbs_we_i;
  assign w_csr_rd  = w_req && !w_rx_hit && !wbs.wbs_we_i;
  assign w_rx_rd   = w_req && w_rx_hit && !wbs.wbs_we_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_req) w_state_nxt = w_rx_rd ? StMemReq : StAck;
      StMemReq: w_state_nxt = StMemCap;
      StMemCap: w_state_nxt = StAck;
      StAck:    w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_csr_rdata = '0;
    if (w_csr_hit) begin
      for (int k = 0; k < NUM_RW; k++) begin
        if (w_idx == 10'(k)) w_csr_rdata = r_rw[k];
      end
      for (int k = 0; k < NUM_RO; k++) begin
        if (w_idx == RO_BASE_W + 10'(k)) w_csr_rdata = ro_i[32*k +: 32];
      end
      if (w_idx == STATUS_W) w_csr_rdata = 32'(w_status);
      if (w_idx == IRQ_EN_W) w_csr_rdata = 32'(w_irq_en);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= StIdle;
      r_dat     <= '0;
      r_rx_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_csr_rd) r_dat <= w_csr_rdata;
      if (w_rx_rd) r_rx_addr <= wbs.wbs_adr_i[RX_MEM_AW-1:0];
      if (r_state == StMemCap) r_dat <= 32'(rx_mem_rdata_i);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    for (int k = 0; k < NUM_RW; k++) begin
      if (wb_rst_i) begin
        r_rw[k] <= RW_INIT[32*k +: 32];
      end else if (w_csr_wr && (w_idx == 10'(k))) begin
        r_rw[k] <= (r_rw[k] & ~w_mask) | (wbs.wbs_dat_i & w_mask);
      end
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
    assign rw_o[32*g +: 32] = r_rw[g];
  end

  assign w_clr   = (w_csr_wr && (w_idx == STATUS_W)) ?
                   (wbs.wbs_dat_i[NUM_STAT-1:0] & w_mask[NUM_STAT-1:0]) : '0;
  assign w_en_we = w_csr_wr && (w_idx == IRQ_EN_W);

  wb_csr_status #(
    .NUM_STAT (NUM_STAT)
  ) u_status (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .i_evt      (stat_evt_i),
    .i_clr      (w_clr),
    .i_en_we    (w_en_we),
    .i_en_wdata (wbs.wbs_dat_i[NUM_STAT-1:0]),
    .i_en_mask  (w_mask[NUM_STAT-1:0]),
    .o_status   (w_status),
    .o_irq_en   (w_irq_en),
    .o_irq      (irq_o)
  );

  assign wbs.wbs_ack_o = (r_state == StAck);
  assign wbs.wbs_dat_o = r_dat;
  assign rx_mem_re_o   = (r_state == StMemReq);
  assign rx_mem_addr_o = r_rx_addr;

endmodule
